// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter in front of a shared N-way mux. One of N_REQ
//   requesters is granted at a time. The grant, the binary select and the
//   forwarded data word come out together. A hold limit forces rotation,
//   so a requester that keeps its request up cannot starve the others.
//
//   Request/grant protocol: a requester raises req_i[k] and keeps it high
//   while it wants the mux. It owns the mux in every cycle where gnt_o[k]
//   is high. It releases the mux by dropping req_i[k]; the release is seen
//   at the next rising edge. The arbiter never grants a requester whose
//   req_i bit is low at the deciding edge.
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   req_i    per-requester request, bit k = requester k
//   data_i   packed data words, requester k at [k*DATA_W +: DATA_W]
//   gnt_o    registered grant, zero or one-hot
//   sel_o    registered binary index of the grantee; keeps its value when idle
//   valid_o  |gnt_o
//   out_o    granted data word, 0 when nothing is granted
//   busy_o   valid_o and at least one other requester is waiting
module rr_mux_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    valid_o,
  output logic [DATA_W-1:0]       out_o,
  output logic                    busy_o
);

  // Width of the hold counter. It has to reach MAX_HOLD-1 and it is never
  // narrower than one bit.
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(N_REQ - 1);
  localparam logic [SEL_W:0]    N_WIDE    = (SEL_W+1)'(N_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;   // most recent winner; the search starts after it
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               waiting;          // some requester other than the grantee is asking
  logic               cur_req;          // the grantee still asks for the mux
  logic [N_REQ-1:0]   cand;             // requesters eligible for the search
  logic [SEL_W-1:0]   start_idx;        // (last+1) mod N_REQ
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;              // cand rotated so bit 0 is start_idx
  logic [SEL_W-1:0]   off;
  logic [SEL_W:0]     sum;
  logic               found;
  logic [SEL_W-1:0]   win;

  assign waiting = |(req_i & ~gnt_q);
  assign cur_req = |(req_i & gnt_q);

  // Round-robin search. In GRANT, last_q is the grantee. It is masked out,
  // so a forced rotation never picks the grantee again. In IDLE every
  // request takes part, and the previous winner comes last in the order.
  always_comb begin
    cand = req_i;
    if (state_q == ST_GRANT) begin
      cand = req_i & ~gnt_q;
    end
    start_idx = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    dbl       = {cand, cand};
    rot       = N_REQ'(dbl >> start_idx);
    off       = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = SEL_W'(j);
      end
    end
    sum = {1'b0, start_idx} + {1'b0, off};
    if (sum >= N_WIDE) begin
      sum = sum - N_WIDE;
    end
    win   = sum[SEL_W-1:0];
    found = |cand;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= LAST_IDX;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          gnt_d   = N_REQ'(1) << win;
          sel_d   = win;
          last_d  = win;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!cur_req) begin
          // A release wins over the hold limit. The next waiter (if any)
          // takes over on the same edge, so there is no idle bubble.
          if (found) begin
            gnt_d  = N_REQ'(1) << win;
            sel_d  = win;
            last_d = win;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
          hold_d = '0;
        end else if (waiting && (hold_q == HOLD_LAST)) begin
          // Forced rotation. The old grantee's request stays pending.
          gnt_d  = N_REQ'(1) << win;
          sel_d  = win;
          last_d = win;
          hold_d = '0;
        end else if (waiting) begin
          hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        end else begin
          // A lone requester keeps the mux for as long as it asks.
          hold_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    gnt_o   = gnt_q;
    sel_o   = sel_q;
    valid_o = |gnt_q;
    busy_o  = (|gnt_q) && waiting;
    out_o   = '0;
    if (|gnt_q) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (sel_q == SEL_W'(k)) begin
          out_o = data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
